// File: rtl/change_pkg.sv
// Shared types and constants for the coin change dispenser: FSM states,
// coin_sel encodings, denomination values and the default ack timeout.
package change_pkg;

    localparam int unsigned AmtW = 5;
    localparam int unsigned AckTimeoutDefault = 15;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSelect  = 3'd1,
        StEject   = 3'd2,
        StWaitAck = 3'd3,
        StDone    = 3'd4,
        StFault   = 3'd5
    } state_e;

    localparam logic [1:0] CoinNone = 2'b00;
    localparam logic [1:0] CoinOne  = 2'b01;
    localparam logic [1:0] CoinFive = 2'b10;
    localparam logic [1:0] CoinTen  = 2'b11;

    localparam logic [AmtW-1:0] Denom10 = 5'd10;
    localparam logic [AmtW-1:0] Denom5  = 5'd5;
    localparam logic [AmtW-1:0] Denom1  = 5'd1;

    // Bit positions of each hopper in hopper_empty.
    localparam int unsigned HopIdx10 = 2;
    localparam int unsigned HopIdx5  = 1;
    localparam int unsigned HopIdx1  = 0;

    function automatic logic [1:0] coin_encode(input logic [AmtW-1:0] denom);
        logic [1:0] sel;
        case (denom)
            Denom10: sel = CoinTen;
            Denom5:  sel = CoinFive;
            Denom1:  sel = CoinOne;
            default: sel = CoinNone;
        endcase
        return sel;
    endfunction

    function automatic logic [AmtW-1:0] coin_value(input logic [1:0] sel);
        logic [AmtW-1:0] val;
        case (sel)
            CoinTen:  val = Denom10;
            CoinFive: val = Denom5;
            CoinOne:  val = Denom1;
            default:  val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_selector.sv
// Greedy denomination picker: largest coin that fits in the remaining amount
// and whose hopper still has coins.
module coin_selector
    import change_pkg::*;
(
    input  logic [AmtW-1:0] remaining_i,
    input  logic [2:0]      hopper_empty_i,
    output logic [AmtW-1:0] denom_o,
    output logic            found_o
);

    always_comb begin
        denom_o = '0;
        found_o = 1'b0;
        if (remaining_i >= Denom10 && !hopper_empty_i[HopIdx10]) begin
            denom_o = Denom10;
            found_o = 1'b1;
        end else if (remaining_i >= Denom5 && !hopper_empty_i[HopIdx5]) begin
            denom_o = Denom5;
            found_o = 1'b1;
        end else if (remaining_i >= Denom1 && !hopper_empty_i[HopIdx1]) begin
            denom_o = Denom1;
            found_o = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time through the hoppers, waiting
// for a release ack per coin and faulting on ack timeout or missing coins.
module change_dispenser
    import change_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AmtW-1:0] change_amount,
    input  logic            change_valid,
    input  logic [2:0]      hopper_empty,
    input  logic            hopper_ack,
    input  logic            fault_clear,
    output logic [1:0]      coin_sel,
    output logic            coin_eject,
    output logic            busy,
    output logic [AmtW-1:0] remaining,
    output logic            dispense_done,
    output logic            dispense_fault
);

    localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [AmtW-1:0]     remaining_q, remaining_d;
    logic [1:0]          coin_sel_q, coin_sel_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [AmtW-1:0]     sel_denom;
    logic                sel_found;

    coin_selector u_coin_selector (
        .remaining_i    (remaining_q),
        .hopper_empty_i (hopper_empty),
        .denom_o        (sel_denom),
        .found_o        (sel_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            coin_sel_q  <= CoinNone;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_sel_q  <= coin_sel_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_sel_d  = coin_sel_q;
        timer_d     = timer_q;
        unique case (state_q)
            StIdle: begin
                if (change_valid) begin
                    remaining_d = change_amount;
                    state_d     = (change_amount == '0) ? StDone : StSelect;
                end
            end
            StSelect: begin
                if (sel_found) begin
                    coin_sel_d = coin_encode(sel_denom);
                    state_d    = StEject;
                end else begin
                    state_d = StFault;
                end
            end
            StEject: begin
                timer_d = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                // An ack arriving on the final timeout cycle still counts.
                if (hopper_ack) begin
                    remaining_d = remaining_q - coin_value(coin_sel_q);
                    state_d     = (remaining_d == '0) ? StDone : StSelect;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TimerW'(ACK_TIMEOUT)) begin
                        state_d = StFault;
                    end
                end
            end
            StDone: begin
                coin_sel_d = CoinNone;
                state_d    = StIdle;
            end
            StFault: begin
                if (fault_clear) begin
                    remaining_d = '0;
                    coin_sel_d  = CoinNone;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign coin_sel       = coin_sel_q;
    assign remaining      = remaining_q;
    assign coin_eject     = (state_q == StEject);
    assign busy           = (state_q != StIdle);
    assign dispense_done  = (state_q == StDone);
    assign dispense_fault = (state_q == StFault);

endmodule
